// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: operand front end of the bit-serial adder.
// Define SERIAL_FEEDER_PIPE_EN to add a one-word holding register.
module serial_operand_feeder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             add_clr,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_cin,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 2);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLR   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;

   logic add_clr_q, add_clr_d;
   logic ser_a_q, ser_a_d;
   logic ser_b_q, ser_b_d;
   logic ser_cin_q, ser_cin_d;
   logic first_q, first_d;
   logic last_q, last_d;
   logic busy_q, busy_d;

   logic             accept;
   logic             load;
   logic [WIDTH-1:0] ld_a;
   logic [WIDTH-1:0] ld_b;
   logic             ld_cin;

`ifdef SERIAL_FEEDER_PIPE_EN
   logic             hold_full_q, hold_full_d;
   logic [WIDTH-1:0] ha_q, ha_d;
   logic [WIDTH-1:0] hb_q, hb_d;
   logic             hcin_q, hcin_d;

   assign in_ready = (state_q == IDLE) | ~hold_full_q;
`else
   assign in_ready = (state_q == IDLE);
`endif

   assign accept = in_valid & in_ready;

   // Next state, shift datapath and registered output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      add_clr_d = 1'b0;
      ser_a_d   = 1'b0;
      ser_b_d   = 1'b0;
      ser_cin_d = 1'b0;
      first_d   = 1'b0;
      last_d    = 1'b0;
      busy_d    = 1'b0;
      load      = 1'b0;
      ld_a      = op_a;
      ld_b      = op_b;
      ld_cin    = op_cin;
`ifdef SERIAL_FEEDER_PIPE_EN
      hold_full_d = hold_full_q;
      ha_d        = ha_q;
      hb_d        = hb_q;
      hcin_d      = hcin_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (accept) load = 1'b1;
         end
         CLR: begin
            state_d   = SHIFT;
            cnt_d     = '0;
            ser_a_d   = a_q[0];
            ser_b_d   = b_q[0];
            a_d       = a_q >> 1;
            b_d       = b_q >> 1;
            first_d   = 1'b1;
            ser_cin_d = cin_q;
            busy_d    = 1'b1;
         end
         SHIFT: begin
            if (!last_q) begin
               cnt_d     = cnt_q + CW'(1);
               ser_a_d   = a_q[0];
               ser_b_d   = b_q[0];
               a_d       = a_q >> 1;
               b_d       = b_q >> 1;
               last_d    = (cnt_q == CNT_PRE_LAST);
               ser_cin_d = cin_q;
               busy_d    = 1'b1;
            end else begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef SERIAL_FEEDER_PIPE_EN
      // A word arriving while busy parks in the holding register,
      // unless the current word ends this cycle and can take it directly.
      if (accept && state_q != IDLE) begin
         if (state_q == SHIFT && last_q) begin
            load = 1'b1;
         end else begin
            hold_full_d = 1'b1;
            ha_d        = op_a;
            hb_d        = op_b;
            hcin_d      = op_cin;
         end
      end
      if (state_q == SHIFT && last_q && hold_full_q) begin
         load        = 1'b1;
         ld_a        = ha_q;
         ld_b        = hb_q;
         ld_cin      = hcin_q;
         hold_full_d = 1'b0;
      end
`endif

      if (load) begin
         state_d   = CLR;
         cnt_d     = '0;
         a_d       = ld_a;
         b_d       = ld_b;
         cin_d     = ld_cin;
         add_clr_d = 1'b1;
         ser_cin_d = ld_cin;
         busy_d    = 1'b1;
      end
   end

   // State, operand and output flops; async reset clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         add_clr_q <= 1'b0;
         ser_a_q   <= 1'b0;
         ser_b_q   <= 1'b0;
         ser_cin_q <= 1'b0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cin_q     <= cin_d;
         add_clr_q <= add_clr_d;
         ser_a_q   <= ser_a_d;
         ser_b_q   <= ser_b_d;
         ser_cin_q <= ser_cin_d;
         first_q   <= first_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
      end
   end

`ifdef SERIAL_FEEDER_PIPE_EN
   // Holding register for a word accepted while a word is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full_q <= 1'b0;
         ha_q        <= '0;
         hb_q        <= '0;
         hcin_q      <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         ha_q        <= ha_d;
         hb_q        <= hb_d;
         hcin_q      <= hcin_d;
      end
   end
`endif

   assign add_clr   = add_clr_q;
   assign ser_a     = ser_a_q;
   assign ser_b     = ser_b_q;
   assign ser_cin   = ser_cin_q;
   assign ser_first = first_q;
   assign ser_last  = last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder: directed self-checking bench.
// Covers reset, idle, bit order, adder chaining and word spacing.
module tb_serial_operand_feeder;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_cin;
   logic       add_clr;
   logic       ser_a;
   logic       ser_b;
   logic       ser_cin;
   logic       ser_first;
   logic       ser_last;
   logic       busy;

   int n_cmp;
   int n_bad;

   serial_operand_feeder #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_cin    (op_cin),
      .add_clr   (add_clr),
      .ser_a     (ser_a),
      .ser_b     (ser_b),
      .ser_cin   (ser_cin),
      .ser_first (ser_first),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] got;
      got = {in_ready, add_clr, ser_a, ser_b, ser_cin,
             ser_first, ser_last, busy};
      n_cmp++;
      if (got !== 8'b1000_0000) begin
         n_bad++;
         $display("FAIL reset_state got=%b want=10000000", got);
      end
   endtask

   task automatic test_idle();
      int bad_cyc;
      bad_cyc = 0;
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         op_a   = 8'($urandom);
         op_b   = 8'($urandom);
         op_cin = 1'($urandom);
         tick();
         n_cmp++;
         if ({busy, add_clr, ser_a, ser_b, ser_cin,
              ser_first, ser_last} !== 7'b0 || in_ready !== 1'b1) begin
            n_bad++;
            bad_cyc++;
            $display("FAIL idle_quiet cyc=%0d busy=%b clr=%b rdy=%b want 0,0,1",
                     i, busy, add_clr, in_ready);
         end
      end
   endtask

   task automatic test_pattern();
      logic ea [8];
      logic eb [8];
      logic exp_rdy;
      ea = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      eb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_FEEDER_PIPE_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = 1'b0;
`endif
      op_a = 8'h5A;
      op_b = 8'h3C;
      op_cin = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op_a = 8'hFF;
      op_b = 8'hFF;
      n_cmp++;
      if ({add_clr, busy, ser_a, ser_b, ser_first, ser_last, ser_cin}
          !== 7'b1100000 || in_ready !== exp_rdy) begin
         n_bad++;
         $display("FAIL pat_clr clr=%b busy=%b a=%b b=%b f=%b l=%b rdy=%b want 1,1,0,0,0,0,%b",
                  add_clr, busy, ser_a, ser_b, ser_first, ser_last,
                  in_ready, exp_rdy);
      end
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (ser_a !== ea[k] || ser_b !== eb[k] ||
             ser_first !== (k == 0) || ser_last !== (k == 7) ||
             add_clr !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pat_bit%0d a=%b b=%b f=%b l=%b clr=%b busy=%b want %b %b %b %b 0 1",
                     k, ser_a, ser_b, ser_first, ser_last, add_clr, busy,
                     ea[k], eb[k], k == 0, k == 7);
         end
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || ser_a !== 1'b0 ||
          ser_last !== 1'b0) begin
         n_bad++;
         $display("FAIL pat_end busy=%b rdy=%b a=%b last=%b want 0 1 0 0",
                  busy, in_ready, ser_a, ser_last);
      end
   endtask

   task automatic test_chained();
      logic       c;
      logic [7:0] sum;
      int         k;
      c = 1'b0;
      sum = 8'h00;
      k = 0;
      op_a = 8'hFF;
      op_b = 8'h01;
      op_cin = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op_cin = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (add_clr) begin
            c = ser_cin;
            k = 0;
         end else if (busy && k < 8) begin
            sum[k] = ser_a ^ ser_b ^ c;
            c = (ser_a & ser_b) | (ser_a & c) | (ser_b & c);
            k++;
         end
         tick();
      end
      n_cmp++;
      if (sum !== 8'h01 || c !== 1'b1 || k != 8) begin
         n_bad++;
         $display("FAIL chain_sum sum=%h carry=%b bits=%0d want 01 1 8",
                  sum, c, k);
      end
   endtask

   task automatic test_back_to_back();
      int  clr_cyc [$];
      int  sent;
      int  stall;
      int  gap_idle;
      int  n_words;
      int  exp_per;
      logic acc;
`ifdef SERIAL_FEEDER_PIPE_EN
      n_words = 3;
      exp_per = 9;
`else
      n_words = 2;
      exp_per = 10;
`endif
      sent = 0;
      stall = 0;
      gap_idle = 0;
      op_a = 8'h11;
      op_b = 8'h22;
      op_cin = 1'b0;
      in_valid = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         acc = in_valid && in_ready;
         if (in_valid && !in_ready && sent == 2) stall++;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            op_a = op_a + 8'h10;
            op_b = op_b + 8'h10;
            if (sent == n_words) in_valid = 1'b0;
         end
         if (add_clr) clr_cyc.push_back(c);
         if (clr_cyc.size() > 0 && clr_cyc.size() < n_words && !busy)
            gap_idle++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (clr_cyc.size() != n_words) begin
         n_bad++;
         $display("FAIL b2b_words got=%0d want=%0d", clr_cyc.size(), n_words);
      end else begin
         for (int i = 1; i < n_words; i++) begin
            n_cmp++;
            if (clr_cyc[i] - clr_cyc[i-1] != exp_per) begin
               n_bad++;
               $display("FAIL b2b_period%0d got=%0d want=%0d", i,
                        clr_cyc[i] - clr_cyc[i-1], exp_per);
            end
         end
      end
`ifdef SERIAL_FEEDER_PIPE_EN
      n_cmp++;
      if (gap_idle != 0 || stall == 0) begin
         n_bad++;
         $display("FAIL b2b_pipe idle=%0d stall=%0d want idle=0 stall>0",
                  gap_idle, stall);
      end
`else
      n_cmp++;
      if (gap_idle != 1) begin
         n_bad++;
         $display("FAIL b2b_gap idle=%0d want=1", gap_idle);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int extra;
      extra = 0;
      op_a = 8'hA5;
      op_b = 8'h5A;
      op_cin = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_cmp++;
      if (busy !== 1'b1 || ser_cin !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_pre busy=%b cin=%b want 1 1", busy, ser_cin);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if ({in_ready, add_clr, ser_a, ser_b, ser_cin, ser_first,
           ser_last, busy} !== 8'b1000_0000) begin
         n_bad++;
         $display("FAIL rmid_out got=%b want=10000000",
                  {in_ready, add_clr, ser_a, ser_b, ser_cin, ser_first,
                   ser_last, busy});
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (add_clr || busy) extra++;
      end
      n_cmp++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL rmid_after active_cycles=%0d want=0", extra);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      op_a = 8'h00;
      op_b = 8'h00;
      op_cin = 1'b0;
      #1;
      test_reset();
      tick();
      tick();
      reset = 1'b0;
      tick();
      test_idle();
      test_pattern();
      tick();
      test_chained();
      tick();
      test_back_to_back();
      tick();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
